// File: rtl/count_bcd_display.sv
// Samples a free-running count, converts it to 3-digit BCD by sequential double-dabble,
// and scans the result onto an active-low, multiplexed 3-digit 7-segment display.
module count_bcd_display #(
    parameter int CNT_W    = 7,
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [11:0]      bcd_out,
    output logic             upd,
    output logic [6:0]       seg,
    output logic [2:0]       an
);

    localparam int SH_W   = $clog2(CNT_W + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [SH_W-1:0]   LAST_SHIFT = SH_W'(CNT_W - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   shreg_q, shreg_d;
    logic [11:0]        work_q, work_d;
    logic [SH_W-1:0]    shift_cnt_q, shift_cnt_d;

    logic [SCAN_W-1:0]  scan_q;
    logic [1:0]         digit_q;
    logic [3:0]         digit_val;
    logic               blank;
    logic [6:0]         seg_d;
    logic [2:0]         an_d;

    // Double-dabble correction: any digit >= 5 becomes >= 8 after +3, so the shift carries.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        logic [11:0] adj;
        state_d     = state_q;
        shreg_d     = shreg_q;
        work_d      = work_q;
        shift_cnt_d = shift_cnt_q;
        adj         = add3(work_q);
        case (state_q)
            ST_IDLE: begin
                shreg_d     = cnt_in;
                work_d      = '0;
                shift_cnt_d = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                work_d      = {adj[10:0], shreg_q[CNT_W-1]};
                shreg_d     = {shreg_q[CNT_W-2:0], 1'b0};
                shift_cnt_d = shift_cnt_q + 1'b1;
                if (shift_cnt_q == LAST_SHIFT)
                    state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_out <= '0;
            upd     <= 1'b0;
        end else begin
            state_q <= state_d;
            upd     <= (state_q == ST_LOAD);
            if (state_q == ST_LOAD)
                bcd_out <= work_q;
        end
    end

    // NOTE: the working datapath is left unreset; IDLE always reinitialises it before use.
    always_ff @(posedge clk) begin
        shreg_q     <= shreg_d;
        work_q      <= work_d;
        shift_cnt_q <= shift_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q  <= '0;
            digit_q <= 2'd0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q  <= '0;
            digit_q <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            scan_q  <= scan_q + 1'b1;
        end
    end

    // Blanking keeps the digit enable asserted; only the segments go dark.
    always_comb begin
        an_d      = 3'b111;
        digit_val = bcd_out[3:0];
        blank     = 1'b1;
        case (digit_q)
            2'd0: begin
                an_d      = 3'b110;
                digit_val = bcd_out[3:0];
                blank     = 1'b0;
            end
            2'd1: begin
                an_d      = 3'b101;
                digit_val = bcd_out[7:4];
                blank     = (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
            end
            2'd2: begin
                an_d      = 3'b011;
                digit_val = bcd_out[11:8];
                blank     = (bcd_out[11:8] == 4'd0);
            end
            default: ;
        endcase
        seg_d = blank ? 7'h7F : seg_decode(digit_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'h7F;
            an  <= 3'b111;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: conversion scoreboard popped on upd, upd period check,
// digit scan/blanking check and reset behaviour including a reset mid-conversion.
module tb_count_bcd_display;

    localparam int CNT_W    = 7;
    localparam int SCAN_DIV = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cnt_in;
    logic [11:0]      bcd_out;
    logic             upd;
    logic [6:0]       seg;
    logic [2:0]       an;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] sb_q[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    count_bcd_display #(.CNT_W(CNT_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .cnt_in  (cnt_in),
        .bcd_out (bcd_out),
        .upd     (upd),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int idx);
        logic [3:0] h, t, o;
        h = b[11:8];
        t = b[7:4];
        o = b[3:0];
        if (idx == 2) return (h == 0) ? 7'h7F : seg_tab[h];
        if (idx == 1) return (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
        return seg_tab[o];
    endfunction

    // Monitor: pops the scoreboard on every upd pulse and checks the pulse spacing.
    initial begin
        int gap = 0;
        bit gap_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                gap_valid = 0;
                gap = 0;
            end else if (upd === 1'b1) begin
                if (gap_valid) check("upd_period", gap, CNT_W + 2);
                if (sb_q.size() > 0) check("bcd_out", bcd_out, sb_q.pop_front());
                gap = 1;
                gap_valid = 1;
            end else begin
                gap++;
            end
        end
    end

    task automatic wait_upd();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (upd === 1'b1) return;
        end
        check("upd_timeout", 0, 1);
    endtask

    task automatic load_value(input int v);
        wait_upd();
        cnt_in = CNT_W'(v);
        sb_q.push_back(to_bcd(v));
        wait_upd();
    endtask

    task automatic check_scan(input string tag, input logic [11:0] b, input int n);
        logic [2:0] prev;
        bit found = 0;
        int start;
        prev = an;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (an !== prev) found = 1;
            prev = an;
        end
        if (!found) begin
            check({tag, "_scan_timeout"}, 0, 1);
            return;
        end
        case (an)
            3'b110:  start = 0;
            3'b101:  start = 1;
            3'b011:  start = 2;
            default: start = -1;
        endcase
        if (start < 0) begin
            check({tag, "_an_onehot"}, an, 3'b110);
            return;
        end
        for (int k = 0; k < n; k++) begin
            int idx;
            logic [2:0] ea;
            if (k > 0) @(negedge clk);
            idx = (start + k / SCAN_DIV) % 3;
            ea  = (idx == 0) ? 3'b110 : (idx == 1) ? 3'b101 : 3'b011;
            check({tag, "_an"}, an, ea);
            check({tag, "_seg"}, seg, exp_seg(b, idx));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[6] = '{0, 9, 10, 99, 100, 127};
        rst    = 1'b1;
        cnt_in = 7'd55;
        repeat (3) begin
            @(negedge clk);
            check("rst_bcd", bcd_out, 0);
            check("rst_upd", upd, 0);
            check("rst_an", an, 3'b111);
            check("rst_seg", seg, 7'h7F);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_an", an, 3'b110);
        check("post_rst_seg", seg, 7'h40);

        foreach (vals[i]) begin
            wait_upd();
            cnt_in = CNT_W'(vals[i]);
            sb_q.push_back(to_bcd(vals[i]));
        end
        wait_upd();

        wait_upd();
        cnt_in = 7'd42;
        sb_q.push_back(12'h042);
        repeat (3) @(negedge clk);
        cnt_in = 7'd17;
        sb_q.push_back(12'h017);
        wait_upd();
        wait_upd();

        load_value(127);
        check_scan("scan127", 12'h127, 24);
        load_value(7);
        check_scan("blank007", 12'h007, 12);
        load_value(100);
        check_scan("blank100", 12'h100, 12);
        load_value(0);
        check_scan("blank000", 12'h000, 12);

        wait_upd();
        cnt_in = 7'd88;
        @(negedge clk);
        cnt_in = 7'd100;
        repeat (3) begin
            @(negedge clk);
            check("abort_upd", upd, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bcd", bcd_out, 0);
        check("abort_upd_rst", upd, 0);
        check("abort_an", an, 3'b111);
        check("abort_seg", seg, 7'h7F);
        wait_upd();
        check("abort_result", int'(bcd_out == 12'h088 || bcd_out == 12'h100), 1);

        repeat (2) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
